// File: rtl/line_sequencer_pkg.sv
// line_sequencer_pkg: shared state encoding, widths and sizing helper for the line sequencer.
package line_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_CRASH, S_OVER} state_e;
  localparam int GAP_W = 3;
  localparam int LEVEL_W = 4;
  localparam int LEVEL_MAX = 15;
  localparam int GAP_PX = 32;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/line_sequencer_frame_timer.sv
// frame_timer: frame-strobe-qualified reloading down counter with a one-clk expire pulse.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stb_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q;
  // Expires on the strobe that finds the count at zero, so load_val+1 strobes per period.
  assign expire_o = en_i && stb_i && !load_i && (cnt_q == '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && stb_i) cnt_q <= (cnt_q == '0) ? load_val_i : cnt_q - W'(1);
  end
endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: round sequencing, staggered line release, level/gap progression and crash flash.
module line_sequencer
  import line_sequencer_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int STAGGER_FRAMES = 30,
  parameter int FLASH_FRAMES   = 15,
  parameter int FLASH_COUNT    = 4,
  parameter int LEVEL_FRAMES   = 600,
  parameter int GAP_MAX        = 7,
  parameter int GAP_MIN        = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame,
  input  logic                 start,
  input  logic                 crash,
  output logic                 load_counter,
  output logic [NUM_LINES-1:0] start_machine,
  output logic                 run,
  output logic                 flash,
  output logic [GAP_W-1:0]     gap_sel,
  output logic [LEVEL_W-1:0]   level,
  output logic                 game_over
);
  localparam int CNT_W = $clog2(max3(LEVEL_FRAMES, STAGGER_FRAMES, FLASH_FRAMES) + 1);
  localparam int TOG_W = $clog2(2 * FLASH_COUNT + 1);

  state_e               state_q;
  logic                 frame_q, start_q, load_seen_q;
  logic [TOG_W-1:0]     tog_q;
  logic                 load_q, run_q, flash_q, over_q;
  logic [NUM_LINES-1:0] sm_q;
  logic [GAP_W-1:0]     gap_q;
  logic [LEVEL_W-1:0]   level_q;
  logic                 stb, start_edge, go_release, playing, crash_hit;
  logic                 stag_exp, lvl_exp, fl_exp;
  logic [NUM_LINES-1:0] sm_shift;

  assign stb        = frame && !frame_q;
  assign start_edge = start && !start_q;
  assign playing    = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign crash_hit  = playing && crash;
  assign go_release = (state_q == S_LOAD) && stb && load_seen_q;
  // Lines are released in index order, so shifting in a one sets the next bit.
  assign sm_shift   = (sm_q << 1) | NUM_LINES'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      frame_q <= frame;
      start_q <= start;
    end
  end

  frame_timer #(.W(CNT_W)) u_stagger (
    .clk(clk), .reset_n(reset_n), .stb_i(stb), .en_i(state_q == S_RELEASE),
    .load_i(go_release), .load_val_i(CNT_W'(STAGGER_FRAMES - 1)), .expire_o(stag_exp)
  );

  frame_timer #(.W(CNT_W)) u_flash (
    .clk(clk), .reset_n(reset_n), .stb_i(stb), .en_i(state_q == S_CRASH),
    .load_i(crash_hit), .load_val_i(CNT_W'(FLASH_FRAMES - 1)), .expire_o(fl_exp)
  );

  frame_timer #(.W(CNT_W)) u_level (
    .clk(clk), .reset_n(reset_n), .stb_i(stb), .en_i(playing),
    .load_i(go_release), .load_val_i(CNT_W'(LEVEL_FRAMES - 1)), .expire_o(lvl_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      sm_q        <= '0;
      run_q       <= 1'b0;
      flash_q     <= 1'b1;
      gap_q       <= GAP_W'(GAP_MAX);
      level_q     <= '0;
      over_q      <= 1'b0;
      load_seen_q <= 1'b0;
      tog_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: if (start_edge) begin
          state_q     <= S_LOAD;
          load_q      <= 1'b1;
          sm_q        <= '0;
          run_q       <= 1'b0;
          flash_q     <= 1'b1;
          gap_q       <= GAP_W'(GAP_MAX);
          level_q     <= '0;
          over_q      <= 1'b0;
          load_seen_q <= 1'b0;
          tog_q       <= '0;
        end
        S_LOAD: if (stb) begin
          load_seen_q <= 1'b1;
          if (load_seen_q) begin
            load_q  <= 1'b0;
            sm_q    <= sm_shift;
            run_q   <= 1'b1;
            state_q <= (&sm_shift) ? S_RUN : S_RELEASE;
          end
        end
        S_RELEASE, S_RUN: if (crash) begin
          state_q <= S_CRASH;
          run_q   <= 1'b0;
          flash_q <= 1'b0;
          tog_q   <= '0;
        end else begin
          if (state_q == S_RELEASE && stag_exp) begin
            sm_q <= sm_shift;
            if (&sm_shift) state_q <= S_RUN;
          end
          if (lvl_exp) begin
            level_q <= (level_q == LEVEL_W'(LEVEL_MAX)) ? level_q : level_q + LEVEL_W'(1);
            gap_q   <= (gap_q > GAP_W'(GAP_MIN)) ? gap_q - GAP_W'(1) : gap_q;
          end
        end
        S_CRASH: if (fl_exp) begin
          if (tog_q == TOG_W'(2 * FLASH_COUNT - 1)) begin
            state_q <= S_OVER;
            flash_q <= 1'b1;
            over_q  <= 1'b1;
          end else begin
            flash_q <= !flash_q;
            tog_q   <= tog_q + TOG_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_counter  = load_q;
  assign start_machine = sm_q;
  assign run           = run_q;
  assign flash         = flash_q;
  assign gap_sel       = gap_q;
  assign level         = level_q;
  assign game_over     = over_q;
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: directed rounds with randomized frame widths, crash timing and start noise,
// checked against a strobe-count model of the round rules.
module tb_line_sequencer;
  localparam int NL = 3, SF = 2, FF = 1, FC = 2, LF = 4, GMAX = 7, GMIN = 2;

  logic          clk = 1'b0, reset_n = 1'b0, frame = 1'b0, start = 1'b0, crash = 1'b0;
  logic          load_counter, run, flash, game_over;
  logic [NL-1:0] start_machine;
  logic [2:0]    gap_sel;
  logic [3:0]    level;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  line_sequencer #(
    .NUM_LINES(NL), .STAGGER_FRAMES(SF), .FLASH_FRAMES(FF), .FLASH_COUNT(FC),
    .LEVEL_FRAMES(LF), .GAP_MAX(GMAX), .GAP_MIN(GMIN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame(frame), .start(start), .crash(crash),
    .load_counter(load_counter), .start_machine(start_machine), .run(run), .flash(flash),
    .gap_sel(gap_sel), .level(level), .game_over(game_over)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Strobes since release entry determine lines released, level and gap.
  function automatic int exp_lines(input int s);
    return (1 << mn(NL, 1 + s / SF)) - 1;
  endfunction
  function automatic int exp_level(input int s);
    return mn(15, s / LF);
  endfunction
  function automatic int exp_gap(input int s);
    return (GMAX - exp_level(s) > GMIN) ? GMAX - exp_level(s) : GMIN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic exp_all(input string tag, input int ld, input int sm, input int rn,
                         input int fl, input int gp, input int lv, input int go);
    chk({tag, ".load_counter"}, 32'(load_counter), ld);
    chk({tag, ".start_machine"}, 32'(start_machine), sm);
    chk({tag, ".run"}, 32'(run), rn);
    chk({tag, ".flash"}, 32'(flash), fl);
    chk({tag, ".gap_sel"}, 32'(gap_sel), gp);
    chk({tag, ".level"}, 32'(level), lv);
    chk({tag, ".game_over"}, 32'(game_over), go);
  endtask

  task automatic exp_round(input string tag, input int s, input int rn, input int fl, input int go);
    exp_all(tag, 0, exp_lines(s), rn, fl, exp_gap(s), exp_level(s), go);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame period: frame held high 1..3 clk (one strobe), then low.
  task automatic strobe(input bit with_crash);
    int w;
    w = $urandom_range(1, 3);
    frame = 1'b1;
    if (with_crash) crash = 1'b1;
    repeat (w) tick();
    frame = 1'b0;
    repeat (10 - w) tick();
  endtask

  task automatic flash_out(input string tag, input int sf, input bit poke_start);
    for (int j = 1; j <= 2 * FC; j++) begin
      if (poke_start) start = ~start;
      strobe(1'b0);
      if (j < 2 * FC) exp_round(tag, sf, 0, j % 2, 0);
      else exp_round({tag, "_over"}, sf, 0, 1, 1);
    end
  endtask

  initial begin
    int k;
    repeat (8) begin
      frame = 1'($urandom); start = 1'($urandom); crash = 1'($urandom);
      tick();
      exp_all("reset", 0, 0, 0, 1, GMAX, 0, 0);
    end
    frame = 1'b0; start = 1'b0; crash = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    crash = 1'b1;
    tick();
    crash = 1'b0;
    tick();
    exp_all("idle_crash", 0, 0, 0, 1, GMAX, 0, 0);

    start = 1'b1;
    tick();
    exp_all("load_entry", 1, 0, 0, 1, GMAX, 0, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    exp_all("load_start_ign", 1, 0, 0, 1, GMAX, 0, 0);
    strobe(1'b0);
    exp_all("load_strobe1", 1, 0, 0, 1, GMAX, 0, 0);
    strobe(1'b0);
    exp_round("release_entry", 0, 1, 1, 0);
    start = 1'b0;
    for (int s = 1; s <= 64; s++) begin
      strobe(1'b0);
      exp_round($sformatf("r1_s%0d", s), s, 1, 1, 0);
    end

    repeat ($urandom_range(1, 4)) tick();
    crash = 1'b1;
    tick();
    exp_round("crash_mid", 64, 0, 0, 0);
    crash = 1'($urandom_range(0, 1));
    flash_out("r1_flash", 64, 1'b0);
    crash = 1'b0;
    tick();
    exp_round("over_hold", 64, 0, 1, 1);

    start = 1'b1;
    tick();
    exp_all("restart", 1, 0, 0, 1, GMAX, 0, 0);
    start = 1'b0;
    strobe(1'b0);
    strobe(1'b0);
    exp_round("r2_release", 0, 1, 1, 0);
    k = LF * $urandom_range(1, 4);
    for (int s = 1; s < k; s++) begin
      strobe(1'b0);
      exp_round($sformatf("r2_s%0d", s), s, 1, 1, 0);
    end
    strobe(1'b1);
    exp_round($sformatf("crash_levelup_k%0d", k), k - 1, 0, 0, 0);
    crash = 1'b0;
    flash_out("r2_flash", k - 1, 1'b1);
    start = 1'b0;

    tick();
    start = 1'b1;
    tick();
    exp_all("restart2", 1, 0, 0, 1, GMAX, 0, 0);
    start = 1'b0;
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    exp_round("r3_s1", 1, 1, 1, 0);
    #2 reset_n = 1'b0;
    #1 exp_all("async_reset", 0, 0, 0, 1, GMAX, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_all("post_reset", 0, 0, 0, 1, GMAX, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
